// File: rtl/intersection_phase_scheduler.sv
// ---------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Two-way intersection controller. Arbitrates NS traffic, EW traffic and
// pedestrian requests in strict rotation (NS -> EW -> PED -> NS) and
// sequences green / yellow / all-red / walk phases with a per-phase timer.
// Every change of right-of-way passes through the all-red clearance state,
// so the two approaches can never show non-red at the same time.
//
// Light encoding: green = 2'b10, yellow = 2'b01, red = 2'b00.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   ns_car       in   1  NS vehicle sensor (level, not latched)
//   ew_car       in   1  EW vehicle sensor (level, not latched)
//   ped_button   in   1  pedestrian request (pulse or level, latched)
//   ns_light     out  2  NS light code
//   ew_light     out  2  EW light code
//   ped_walk     out  1  walk indication, high only in WALK
//   ped_pending  out  1  latched pedestrian request
//   phase        out  3  current state code (debug)
// ---------------------------------------------------------------------------
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 10,
    parameter int TW        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_button,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic [TW-1:0] L_GREEN_MIN_M1 = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] L_GREEN_MAX_M1 = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] L_YELLOW_M1    = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] L_ALLRED_M1    = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] L_WALK_M1      = TW'(WALK_T - 1);

    typedef enum logic [2:0] {
        S_RED_CLR = 3'd0,
        S_NS_G    = 3'd1,
        S_NS_Y    = 3'd2,
        S_EW_G    = 3'd3,
        S_EW_Y    = 3'd4,
        S_WALK    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRV_NS  = 2'd0,
        SRV_EW  = 2'd1,
        SRV_PED = 2'd2
    } served_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic          r_ped_req;
    logic          w_ped_req_next;
    served_t       r_last;
    served_t       w_last_next;
    served_t       w_grant;
    logic          w_any_pending;
    logic          w_ns_exit;
    logic          w_ew_exit;
    logic          w_is_green;

    // Rotating-priority grant: scan starts at the requester after the one
    // served last. Only consulted when something is pending.
    always_comb begin
        w_any_pending = ns_car | ew_car | r_ped_req;
        w_grant       = SRV_NS;
        case (r_last)
            SRV_NS: begin
                if (ew_car)         w_grant = SRV_EW;
                else if (r_ped_req) w_grant = SRV_PED;
                else                w_grant = SRV_NS;
            end
            SRV_EW: begin
                if (r_ped_req)      w_grant = SRV_PED;
                else if (ns_car)    w_grant = SRV_NS;
                else                w_grant = SRV_EW;
            end
            default: begin
                if (ns_car)         w_grant = SRV_NS;
                else if (ew_car)    w_grant = SRV_EW;
                else                w_grant = SRV_PED;
            end
        endcase
    end

    // Green termination: only when someone else is waiting. Gap-out once the
    // minimum green has elapsed and the own approach is empty; max-out
    // regardless of own demand.
    always_comb begin
        w_ns_exit = (ew_car | r_ped_req) &&
                    (((r_timer >= L_GREEN_MIN_M1) && !ns_car) ||
                     (r_timer >= L_GREEN_MAX_M1));
        w_ew_exit = (ns_car | r_ped_req) &&
                    (((r_timer >= L_GREEN_MIN_M1) && !ew_car) ||
                     (r_timer >= L_GREEN_MAX_M1));
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            S_RED_CLR: begin
                if (r_timer == L_ALLRED_M1) begin
                    if (w_any_pending) begin
                        w_last_next = w_grant;
                        case (w_grant)
                            SRV_NS:  w_state_next = S_NS_G;
                            SRV_EW:  w_state_next = S_EW_G;
                            default: w_state_next = S_WALK;
                        endcase
                    end else begin
                        // Rest state: park on NS green
                        w_state_next = S_NS_G;
                        w_last_next  = SRV_NS;
                    end
                end
            end
            S_NS_G: if (w_ns_exit)                w_state_next = S_NS_Y;
            S_NS_Y: if (r_timer == L_YELLOW_M1)   w_state_next = S_RED_CLR;
            S_EW_G: if (w_ew_exit)                w_state_next = S_EW_Y;
            S_EW_Y: if (r_timer == L_YELLOW_M1)   w_state_next = S_RED_CLR;
            S_WALK: if (r_timer == L_WALK_M1)     w_state_next = S_RED_CLR;
            default:                              w_state_next = S_RED_CLR;
        endcase
    end

    // Timer restarts on every state change; in green it saturates so that a
    // long uncontested green keeps the max-out condition armed.
    always_comb begin
        w_is_green = (r_state == S_NS_G) || (r_state == S_EW_G);
        if (w_state_next != r_state) begin
            w_timer_next = '0;
        end else if (w_is_green && (r_timer >= L_GREEN_MAX_M1)) begin
            w_timer_next = r_timer;
        end else begin
            w_timer_next = r_timer + TW'(1);
        end
    end

    // Pedestrian latch: the clear on WALK entry wins over a simultaneous
    // button press; a press during WALK re-arms the request.
    always_comb begin
        w_ped_req_next = r_ped_req | ped_button;
        if ((w_state_next == S_WALK) && (r_state != S_WALK)) begin
            w_ped_req_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RED_CLR;
            r_timer   <= '0;
            r_ped_req <= 1'b0;
            r_last    <= SRV_PED;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_ped_req <= w_ped_req_next;
            r_last    <= w_last_next;
        end
    end

    // Moore outputs
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        ped_walk = 1'b0;
        case (r_state)
            S_NS_G: ns_light = LIGHT_GREEN;
            S_NS_Y: ns_light = LIGHT_YELLOW;
            S_EW_G: ew_light = LIGHT_GREEN;
            S_EW_Y: ew_light = LIGHT_YELLOW;
            S_WALK: ped_walk = 1'b1;
            default: ;
        endcase
    end

    assign ped_pending = r_ped_req;
    assign phase       = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;
    localparam int WALK_T    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_button = 1'b0;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    intersection_phase_scheduler #(
        .GREEN_MIN(GREEN_MIN),
        .GREEN_MAX(GREEN_MAX),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .WALK_T   (WALK_T),
        .TW       (5)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .ns_car     (ns_car),
        .ew_car     (ew_car),
        .ped_button (ped_button),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ped_walk   (ped_walk),
        .ped_pending(ped_pending),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Phases by name number: 0 all-red, 1 NS green, 2 NS yellow,
    // 3 EW green, 4 EW yellow, 5 walk. Requesters: 0 NS, 1 EW, 2 PED.
    int m_phase   = 0;
    int m_elapsed = 0;   // cycles already spent in the current phase
    bit m_ped     = 0;
    int m_last    = 2;
    bit m_valid   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nxt;
        int  idx;
        bit  found;
        bit  pend [3];
        int  grant_phase [3];
        bit  comp;
        bit  own;
        grant_phase = '{1, 3, 5};
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_ped = 0; m_last = 2; m_valid = 1;
            return;
        end
        if (!m_valid) return;
        pend[0] = ns_car; pend[1] = ew_car; pend[2] = m_ped;
        nxt = m_phase;
        if (m_phase == 0) begin
            if (m_elapsed >= ALLRED_T - 1) begin
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (!found && pend[idx]) begin
                        found  = 1;
                        m_last = idx;
                        nxt    = grant_phase[idx];
                    end
                end
                if (!found) begin
                    nxt = 1; m_last = 0;
                end
            end
        end else if (m_phase == 1 || m_phase == 3) begin
            own  = (m_phase == 1) ? ns_car : ew_car;
            comp = ((m_phase == 1) ? ew_car : ns_car) | m_ped;
            if (comp && ((m_elapsed >= GREEN_MIN - 1 && !own) || m_elapsed >= GREEN_MAX - 1))
                nxt = m_phase + 1;
        end else if (m_phase == 2 || m_phase == 4) begin
            if (m_elapsed >= YELLOW_T - 1) nxt = 0;
        end else if (m_phase == 5) begin
            if (m_elapsed >= WALK_T - 1) nxt = 0;
        end else begin
            nxt = 0;
        end
        if (nxt == 5 && m_phase != 5) m_ped = 0;
        else if (ped_button)          m_ped = 1;
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
    endtask

    function automatic int model_word();
        logic [1:0] n;
        logic [1:0] e;
        n = 2'b00; e = 2'b00;
        case (m_phase)
            1: n = 2'b10;
            2: n = 2'b01;
            3: e = 2'b10;
            4: e = 2'b01;
            default: ;
        endcase
        return int'({3'(m_phase), n, e, (m_phase == 5), m_ped});
    endfunction

    function automatic int dut_word();
        return int'({phase, ns_light, ew_light, ped_walk, ped_pending});
    endfunction

    // One clock: model advances on the inputs now applied, then the DUT is
    // sampled 1 time unit after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (m_valid) chk("model", dut_word(), model_word());
        chk("safety", int'(ns_light != 2'b00 && ew_light != 2'b00), 0);
    endtask

    task automatic do_reset();
        rst = 1; ns_car = 0; ew_car = 0; ped_button = 0;
        tick(); tick();
        rst = 0;
    endtask

    // Counts consecutive observations of phase ph (current one included).
    task automatic run_len(input int ph, output int n);
        n = 0;
        while (int'(phase) == ph && n < 300) begin
            n++;
            tick();
        end
        if (n >= 300) chk("run_len_timeout", n, -1);
    endtask

    typedef struct {
        bit         rst;
        bit         ns;
        bit         ew;
        bit         ped;
        int         ph;
        bit [1:0]   nsl;
        bit [1:0]   ewl;
        bit         walk;
        bit         pend;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int n;
        int seq [16];
        int exp_seq [16];
        int cnt;
        int prev;
        int guard;

        // ------------- table-driven vectors -------------
        // Reset, rest on NS green, ped press -> gap-out into WALK, re-press in WALK
        vecs[0]  = '{1,0,0,0, 0, 2'b00, 2'b00, 0, 0};
        vecs[1]  = '{1,0,0,0, 0, 2'b00, 2'b00, 0, 0};
        vecs[2]  = '{0,0,0,0, 0, 2'b00, 2'b00, 0, 0};
        vecs[3]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 0};
        vecs[4]  = '{0,0,0,1, 1, 2'b10, 2'b00, 0, 1};
        vecs[5]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[6]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[7]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[8]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[9]  = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[10] = '{0,0,0,0, 1, 2'b10, 2'b00, 0, 1};
        vecs[11] = '{0,0,0,0, 2, 2'b01, 2'b00, 0, 1};
        vecs[12] = '{0,0,0,0, 2, 2'b01, 2'b00, 0, 1};
        vecs[13] = '{0,0,0,0, 2, 2'b01, 2'b00, 0, 1};
        vecs[14] = '{0,0,0,0, 0, 2'b00, 2'b00, 0, 1};
        vecs[15] = '{0,0,0,0, 0, 2'b00, 2'b00, 0, 1};
        vecs[16] = '{0,0,0,0, 5, 2'b00, 2'b00, 1, 0};
        vecs[17] = '{0,0,0,1, 5, 2'b00, 2'b00, 1, 1};
        vecs[18] = '{0,0,0,0, 5, 2'b00, 2'b00, 1, 1};

        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; ns_car = vecs[i].ns; ew_car = vecs[i].ew; ped_button = vecs[i].ped;
            tick();
            chk($sformatf("vec%0d", i), dut_word(),
                int'({3'(vecs[i].ph), vecs[i].nsl, vecs[i].ewl, vecs[i].walk, vecs[i].pend}));
            $display("vec %0d phase %0d ns %b ew %b walk %b pend %b",
                     i, phase, ns_light, ew_light, ped_walk, ped_pending);
        end

        // ------------- rest: 100 cycles of NS green -------------
        do_reset();
        chk("rest_reset_phase", int'(phase), 0);
        tick(); chk("rest_redclr", int'(phase), 0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (phase == 3'd1 && ns_light == 2'b10 && !ped_walk) n++;
        end
        chk("rest_ns_green_cycles", n, 100);
        $display("scenario rest ns_green_cycles %0d", n);

        // ------------- gap-out -------------
        do_reset(); tick(); tick();
        chk("gap_start", int'(phase), 1);
        ew_car = 1;
        run_len(1, n); chk("gap_green_len", n, 8);
        chk("gap_to_yellow", int'(phase), 2);
        run_len(2, n); chk("gap_yellow_len", n, 3);
        run_len(0, n); chk("gap_allred_len", n, 2);
        chk("gap_ew_green", int'({phase, ew_light}), int'({3'd3, 2'b10}));
        $display("scenario gapout done phase %0d", phase);

        // ------------- max-out -------------
        do_reset(); tick(); tick();
        ns_car = 1; ew_car = 1;
        run_len(1, n); chk("max_green_len", n, 20);
        chk("max_to_yellow", int'(phase), 2);
        $display("scenario maxout green_len %0d", n);

        // ------------- pedestrian -------------
        do_reset(); tick(); tick();
        for (int i = 0; i < 10; i++) tick();
        ped_button = 1; tick(); ped_button = 0;
        chk("ped_pending_rise", int'(ped_pending), 1);
        run_len(1, n); chk("ped_green_rest", n, 1);
        run_len(2, n); chk("ped_yellow_len", n, 3);
        run_len(0, n); chk("ped_allred_len", n, 2);
        chk("ped_walk_entry", int'({phase, ped_walk, ped_pending}), int'({3'd5, 1'b1, 1'b0}));
        run_len(5, n); chk("ped_walk_len", n, 10);
        run_len(0, n); chk("ped_allred2_len", n, 2);
        chk("ped_back_ns", int'(phase), 1);
        $display("scenario pedestrian done phase %0d", phase);

        // ------------- rotation fairness -------------
        exp_seq = '{1, 2, 0, 3, 4, 0, 5, 0, 1, 2, 0, 3, 4, 0, 5, 0};
        do_reset();
        ns_car = 1; ew_car = 1; ped_button = 1;
        prev = int'(phase); cnt = 0; guard = 0;
        while (cnt < 16 && guard < 600) begin
            tick(); guard++;
            if (int'(phase) != prev) begin
                seq[cnt] = int'(phase);
                cnt++;
                prev = int'(phase);
            end
        end
        chk("rot_transitions", cnt, 16);
        for (int i = 0; i < cnt; i++) chk($sformatf("rot_step%0d", i), seq[i], exp_seq[i]);
        $display("scenario rotation transitions %0d cycles %0d", cnt, guard);
        ped_button = 0; ns_car = 0; ew_car = 0;

        // ------------- mid-phase reset -------------
        do_reset();
        ew_car = 1; tick(); tick();
        chk("mrst_ew_green", int'(phase), 3);
        ew_car = 0; ns_car = 1; ped_button = 1; tick(); ped_button = 0;
        run_len(3, n);
        chk("mrst_ew_yellow", int'(phase), 4);
        tick();
        chk("mrst_pending_before", int'(ped_pending), 1);
        rst = 1; tick();
        chk("mrst_abort", int'({phase, ns_light, ew_light, ped_pending}), 0);
        rst = 0; tick();
        chk("mrst_redclr", int'(phase), 0);
        tick();
        chk("mrst_ns_green", int'({phase, ns_light}), int'({3'd1, 2'b10}));
        $display("scenario midreset done phase %0d", phase);

        // ------------- randomized against the model -------------
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 15) == 0) ns_car = ~ns_car;
            if ($urandom_range(0, 15) == 0) ew_car = ~ew_car;
            ped_button = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 700) == 0);
            tick();
        end
        rst = 0;
        $display("scenario random done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
